maxpool_stream: RTL and testbench
=================================

Name: maxpool_stream

Overview:
- Streaming, multi-channel successor to the combinational binary max-pool.
- Accepts a binarised feature map one input row per beat, with all channels packed in that beat, over a valid/ready handshake.
- Emits one pooled row every POOL_SIZE input rows. Pooling is OR (binary max) over non-overlapping POOL_SIZE x POOL_SIZE windows.
- Sits between a binary conv/activation stage and the next layer, replacing the full-frame flattened input with a row-streamed datapath.

Parameters:
- ISIZE_L, 26, input row length (columns) per channel.
- ISIZE_H, 26, input rows per frame.
- POOL_SIZE, 2, window edge and stride (>=1).
- CH, 1, channels carried in parallel per beat.
- Derived: OL = ISIZE_L/POOL_SIZE, OH = ISIZE_H/POOL_SIZE (floor).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  in_row is valid.
- in_ready  out  1  block can accept a beat this cycle.
- in_row  in  CH*ISIZE_L  one input row; channel c, column j at bit c*ISIZE_L+j.
- out_valid  out  1  out_row is valid.
- out_ready  in  1  downstream accepts out_row.
- out_row  out  CH*OL  pooled row; channel c, column m at bit c*OL+m.
- out_last  out  1  out_row is pooled row OH-1 of the frame.

Behaviour:
- Reset (rst=1 at clk edge): out_valid=0, out_row=0, out_last=0, row counter=0, phase=0, accumulator=0.
- in_ready is forced 0 while rst=1.
- Any partial frame is discarded on reset; the next accepted beat is row 0 of a new frame.
- in_ready = !out_valid || out_ready (combinational). Beat accepted when in_valid && in_ready.
- Horizontal reduce (combinational): h[c*OL+m] = OR of in_row[c*ISIZE_L + m*POOL_SIZE + l], l=0..POOL_SIZE-1. Columns >= OL*POOL_SIZE are ignored.
- State: row_cnt 0..ISIZE_H-1; phase 0..POOL_SIZE-1; prow 0..OH-1; acc[CH*OL].
- On an accepted beat with row_cnt < OH*POOL_SIZE:
  - acc <= (phase==0) ? h : acc|h.
  - phase increments, wrapping at POOL_SIZE-1.
  - If phase==POOL_SIZE-1: out_row <= (phase==0 ? h : acc|h), out_valid <= 1, out_last <= (prow==OH-1), prow increments.
- Accepted beats with row_cnt >= OH*POOL_SIZE (trailing rows) are consumed and produce no output.
- row_cnt increments per accepted beat. After ISIZE_H-1 it wraps to 0, phase and prow also clear, and the next frame starts.
- Output handshake: out_valid && out_ready clears out_valid and out_last next cycle unless a new output loads in the same cycle.
  - Simultaneous drain and load: out_valid stays 1 with the new data.
- out_row and out_last stay stable while out_valid && !out_ready.
- Latency: output registered 1 cycle after the completing input beat. Throughput 1 row/cycle with no bubbles when out_ready=1.
- POOL_SIZE=1: every beat within range produces out_row = in_row.
- in_row with in_valid=0 is don't-care and never updates state.

Optional Feature:
- Macro: MAXPOOL_STREAM_FRAME_CNT_EN.
- Defined: adds output port frame_cnt [15:0].
  - Reset to 0.
  - Increments (wrapping at 16'hFFFF to 0) on each out handshake where out_last=1.
- Undefined: port and counter absent; all other behaviour is identical.

Test Plan:
- ISIZE_L=ISIZE_H=4, P=2, CH=1. Rows 4'b0001, 4'b0000, 4'b1000, 4'b0000 with out_ready=1 -> out_row=2'b01 (out_last=0) 1 cycle after beat 1; out_row=2'b10 (out_last=1) 1 cycle after beat 3.
- Same config, CH=2. Row0 = {ch1:4'b0100, ch0:4'b0000}, row1 = {4'b0000, 4'b0010} -> out_row = {2'b10, 2'b01} = 4'b1001.
- ISIZE_L=ISIZE_H=5, P=2. Column 4 and row 4 all ones, all else 0 -> outputs 2'b00, 2'b00; row 4 accepted with in_ready=1 and no output.
- Backpressure: hold out_ready=0 after the first output -> in_ready=0, out_row stable for 10 cycles. Raise out_ready -> the next beat is accepted in the same cycle and the stream continues with no loss.
- Assert rst after row 1 of a frame -> out_valid=0 next cycle; rows 0..3 resent -> correct frame output with no mixing from the aborted frame.
- With MAXPOOL_STREAM_FRAME_CNT_EN: 3 back-to-back frames -> frame_cnt=3. Preload via 65536 frames (or force) -> wraps to 0.

Source files
------------

// File: rtl/maxpool_stream.sv
// ============================================================================
// Module   : maxpool_stream
// Brief    : Row-streamed multi-channel binary (OR) max-pool with valid/ready
//            handshake. Optional MAXPOOL_STREAM_FRAME_CNT_EN adds frame_cnt.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module maxpool_stream #(
    parameter int ISIZE_L   = 26,
    parameter int ISIZE_H   = 26,
    parameter int POOL_SIZE = 2,
    parameter int CH        = 1
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    in_valid,
    output logic                                    in_ready,
    input  logic [CH*ISIZE_L-1:0]                   in_row,
    output logic                                    out_valid,
    input  logic                                    out_ready,
    output logic [CH*(ISIZE_L/POOL_SIZE)-1:0]       out_row,
    output logic                                    out_last
`ifdef MAXPOOL_STREAM_FRAME_CNT_EN
    ,
    output logic [15:0]                             frame_cnt
`endif
);

    localparam int OL  = ISIZE_L / POOL_SIZE;
    localparam int OH  = ISIZE_H / POOL_SIZE;
    localparam int OW  = CH * OL;
    localparam int RCW = $clog2(ISIZE_H + 1);
    localparam int PHW = (POOL_SIZE > 1) ? $clog2(POOL_SIZE) : 1;
    localparam int PRW = (OH > 0) ? $clog2(OH + 1) : 1;

    localparam logic [RCW-1:0] c_ROW_LAST  = RCW'(ISIZE_H - 1);
    localparam logic [RCW-1:0] c_ROW_LIM   = RCW'(OH * POOL_SIZE);
    localparam logic [RCW-1:0] c_ROW_ONE   = RCW'(1);
    localparam logic [PHW-1:0] c_PH_LAST   = PHW'(POOL_SIZE - 1);
    localparam logic [PHW-1:0] c_PH_ONE    = PHW'(1);
    localparam logic [PRW-1:0] c_PROW_LAST = PRW'(OH - 1);
    localparam logic [PRW-1:0] c_PROW_ONE  = PRW'(1);

    logic [RCW-1:0] r_row_cnt;
    logic [PHW-1:0] r_phase;
    logic [PRW-1:0] r_prow;
    logic [OW-1:0]  r_acc;
    logic [OW-1:0]  r_out_row;
    logic           r_out_valid;
    logic           r_out_last;

    logic [OW-1:0]  w_h;
    logic [OW-1:0]  w_merge;
    logic           w_accept;
    logic           w_in_range;
    logic           w_unused_row;

    // Columns past OL*POOL_SIZE never reach a window.
    assign w_unused_row = ^in_row;

    for (genvar c = 0; c < CH; c++) begin : g_ch
        for (genvar m = 0; m < OL; m++) begin : g_col
            assign w_h[c*OL+m] = |in_row[c*ISIZE_L + m*POOL_SIZE +: POOL_SIZE];
        end
    end

    assign in_ready   = !rst && (!r_out_valid || out_ready);
    assign w_accept   = in_valid && in_ready;
    assign w_in_range = (r_row_cnt < c_ROW_LIM);
    assign w_merge    = (r_phase == '0) ? w_h : (r_acc | w_h);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_row_cnt   <= '0;
            r_phase     <= '0;
            r_prow      <= '0;
            r_acc       <= '0;
            r_out_row   <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else begin
            // A load below overrides this drain when both happen together.
            if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
            end
            if (w_accept) begin
                if (w_in_range) begin
                    r_acc <= w_merge;
                    if (r_phase == c_PH_LAST) begin
                        r_phase     <= '0;
                        r_out_row   <= w_merge;
                        r_out_valid <= 1'b1;
                        r_out_last  <= (r_prow == c_PROW_LAST);
                        r_prow      <= r_prow + c_PROW_ONE;
                    end else begin
                        r_phase <= r_phase + c_PH_ONE;
                    end
                end
                if (r_row_cnt == c_ROW_LAST) begin
                    r_row_cnt <= '0;
                    r_phase   <= '0;
                    r_prow    <= '0;
                end else begin
                    r_row_cnt <= r_row_cnt + c_ROW_ONE;
                end
            end
        end
    end

    assign out_row   = r_out_row;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;

`ifdef MAXPOOL_STREAM_FRAME_CNT_EN
    logic [15:0] r_frame_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_cnt <= '0;
        end else if (r_out_valid && out_ready && r_out_last) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end

    assign frame_cnt = r_frame_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_maxpool_stream.sv
// ============================================================================
// Module   : tb_maxpool_stream
// Brief    : Directed self-checking bench for maxpool_stream (three configs).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_maxpool_stream;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    // A: 4x4, P=2, CH=2
    logic       a_in_valid = 1'b0;
    logic       a_in_ready;
    logic [7:0] a_in_row   = '0;
    logic       a_out_valid;
    logic       a_out_ready = 1'b1;
    logic [3:0] a_out_row;
    logic       a_out_last;
    // C: 5x5, P=2, CH=1
    logic       c_in_valid = 1'b0;
    logic       c_in_ready;
    logic [4:0] c_in_row   = '0;
    logic       c_out_valid;
    logic       c_out_ready = 1'b1;
    logic [1:0] c_out_row;
    logic       c_out_last;
    // P: 4 cols x 3 rows, P=1, CH=1
    logic       p_in_valid = 1'b0;
    logic       p_in_ready;
    logic [3:0] p_in_row   = '0;
    logic       p_out_valid;
    logic       p_out_ready = 1'b1;
    logic [3:0] p_out_row;
    logic       p_out_last;
`ifdef MAXPOOL_STREAM_FRAME_CNT_EN
    logic [15:0] a_frame_cnt;
    logic [15:0] c_frame_cnt;
    logic [15:0] p_frame_cnt;
`endif

    maxpool_stream #(.ISIZE_L(4), .ISIZE_H(4), .POOL_SIZE(2), .CH(2)) u_a (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_row(a_in_row),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_row(a_out_row), .out_last(a_out_last)
`ifdef MAXPOOL_STREAM_FRAME_CNT_EN
        , .frame_cnt(a_frame_cnt)
`endif
    );

    maxpool_stream #(.ISIZE_L(5), .ISIZE_H(5), .POOL_SIZE(2), .CH(1)) u_c (
        .clk(clk), .rst(rst),
        .in_valid(c_in_valid), .in_ready(c_in_ready), .in_row(c_in_row),
        .out_valid(c_out_valid), .out_ready(c_out_ready),
        .out_row(c_out_row), .out_last(c_out_last)
`ifdef MAXPOOL_STREAM_FRAME_CNT_EN
        , .frame_cnt(c_frame_cnt)
`endif
    );

    maxpool_stream #(.ISIZE_L(4), .ISIZE_H(3), .POOL_SIZE(1), .CH(1)) u_p (
        .clk(clk), .rst(rst),
        .in_valid(p_in_valid), .in_ready(p_in_ready), .in_row(p_in_row),
        .out_valid(p_out_valid), .out_ready(p_out_ready),
        .out_row(p_out_row), .out_last(p_out_last)
`ifdef MAXPOOL_STREAM_FRAME_CNT_EN
        , .frame_cnt(p_frame_cnt)
`endif
    );

    // Inputs change and outputs are sampled at the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        chk_cnt++;
        if ({a_in_ready, a_out_valid, a_out_last, a_out_row} !== 7'b0) begin
            $display("FAIL reset_a: got rdy/v/l/row=%b want 0000000",
                     {a_in_ready, a_out_valid, a_out_last, a_out_row});
        end else pass_cnt++;
        chk_cnt++;
        if ({c_in_ready, c_out_valid, c_out_last, c_out_row} !== 5'b0) begin
            $display("FAIL reset_c: got rdy/v/l/row=%b want 00000",
                     {c_in_ready, c_out_valid, c_out_last, c_out_row});
        end else pass_cnt++;
        chk_cnt++;
        if ({p_in_ready, p_out_valid, p_out_last, p_out_row} !== 7'b0) begin
            $display("FAIL reset_p: got rdy/v/l/row=%b want 0000000",
                     {p_in_ready, p_out_valid, p_out_last, p_out_row});
        end else pass_cnt++;
        rst = 1'b0;
        #1;
        chk_cnt++;
        if ({a_in_ready, c_in_ready, p_in_ready} !== 3'b111) begin
            $display("FAIL ready_after_reset: got %b want 111",
                     {a_in_ready, c_in_ready, p_in_ready});
        end else pass_cnt++;
        tick();
    endtask

    task automatic test_single_channel();
        a_out_ready = 1'b1;
        a_in_valid  = 1'b1;
        a_in_row = 8'h01; tick();
        a_in_row = 8'h00; tick();
        chk_cnt++;
        if ({a_out_valid, a_out_last, a_out_row} !== 6'b1_0_0001) begin
            $display("FAIL single_row0: got v/l/row=%b want 100001",
                     {a_out_valid, a_out_last, a_out_row});
        end else pass_cnt++;
        a_in_row = 8'h08; tick();
        chk_cnt++;
        if (a_out_valid !== 1'b0) begin
            $display("FAIL single_drain: got out_valid=%b want 0", a_out_valid);
        end else pass_cnt++;
        a_in_row = 8'h00; tick();
        chk_cnt++;
        if ({a_out_valid, a_out_last, a_out_row} !== 6'b1_1_0010) begin
            $display("FAIL single_row1: got v/l/row=%b want 110010",
                     {a_out_valid, a_out_last, a_out_row});
        end else pass_cnt++;
        a_in_valid = 1'b0; tick();
        chk_cnt++;
        if ({a_out_valid, a_out_last} !== 2'b00) begin
            $display("FAIL single_idle: got v/l=%b want 00", {a_out_valid, a_out_last});
        end else pass_cnt++;
    endtask

    task automatic test_channels();
        a_in_valid = 1'b1;
        a_in_row = 8'b0100_0000; tick();
        a_in_row = 8'b0000_0010; tick();
        chk_cnt++;
        if ({a_out_valid, a_out_last, a_out_row} !== 6'b1_0_1001) begin
            $display("FAIL channels_row0: got v/l/row=%b want 101001",
                     {a_out_valid, a_out_last, a_out_row});
        end else pass_cnt++;
        a_in_row = 8'h00; tick();
        tick();
        chk_cnt++;
        if ({a_out_valid, a_out_last, a_out_row} !== 6'b1_1_0000) begin
            $display("FAIL channels_row1: got v/l/row=%b want 110000",
                     {a_out_valid, a_out_last, a_out_row});
        end else pass_cnt++;
        a_in_valid = 1'b0; tick();
    endtask

    task automatic test_backpressure();
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        a_in_row = 8'b0000_0100; tick();
        a_in_row = 8'h00; tick();
        a_in_row = 8'b0011_0000;
        for (int i = 0; i < 10; i++) begin
            chk_cnt++;
            if ({a_in_ready, a_out_valid, a_out_last, a_out_row} !== 7'b0_1_0_0010) begin
                $display("FAIL stall_cycle%0d: got rdy/v/l/row=%b want 0100010",
                         i, {a_in_ready, a_out_valid, a_out_last, a_out_row});
            end else pass_cnt++;
            tick();
        end
        a_out_ready = 1'b1;
        #1;
        chk_cnt++;
        if (a_in_ready !== 1'b1) begin
            $display("FAIL stall_release_ready: got in_ready=%b want 1", a_in_ready);
        end else pass_cnt++;
        @(negedge clk);
        chk_cnt++;
        if (a_out_valid !== 1'b0) begin
            $display("FAIL stall_release_drain: got out_valid=%b want 0", a_out_valid);
        end else pass_cnt++;
        a_in_row = 8'h00; tick();
        chk_cnt++;
        if ({a_out_valid, a_out_last, a_out_row} !== 6'b1_1_0100) begin
            $display("FAIL stall_continue: got v/l/row=%b want 110100",
                     {a_out_valid, a_out_last, a_out_row});
        end else pass_cnt++;
        a_in_valid = 1'b0; tick();
    endtask

    task automatic test_reset_midframe();
        a_out_ready = 1'b1;
        a_in_valid  = 1'b1;
        a_in_row = 8'hFF; tick();
        tick();
        chk_cnt++;
        if ({a_out_valid, a_out_last, a_out_row} !== 6'b1_0_1111) begin
            $display("FAIL abort_first: got v/l/row=%b want 101111",
                     {a_out_valid, a_out_last, a_out_row});
        end else pass_cnt++;
        tick();
        a_in_valid = 1'b0;
        rst = 1'b1; tick();
        chk_cnt++;
        if ({a_out_valid, a_out_last, a_out_row} !== 6'b0) begin
            $display("FAIL abort_reset: got v/l/row=%b want 000000",
                     {a_out_valid, a_out_last, a_out_row});
        end else pass_cnt++;
        rst = 1'b0;
        a_in_valid = 1'b1;
        a_in_row = 8'h00; tick();
        tick();
        chk_cnt++;
        if ({a_out_valid, a_out_last, a_out_row} !== 6'b1_0_0000) begin
            $display("FAIL abort_resend0: got v/l/row=%b want 100000",
                     {a_out_valid, a_out_last, a_out_row});
        end else pass_cnt++;
        tick();
        a_in_row = 8'h01; tick();
        chk_cnt++;
        if ({a_out_valid, a_out_last, a_out_row} !== 6'b1_1_0001) begin
            $display("FAIL abort_resend1: got v/l/row=%b want 110001",
                     {a_out_valid, a_out_last, a_out_row});
        end else pass_cnt++;
        a_in_valid = 1'b0; tick();
    endtask

    task automatic test_trailing();
        c_out_ready = 1'b1;
        c_in_valid  = 1'b1;
        c_in_row = 5'b10000; tick();
        tick();
        chk_cnt++;
        if ({c_out_valid, c_out_last, c_out_row} !== 4'b1_0_00) begin
            $display("FAIL trail_row0: got v/l/row=%b want 1000",
                     {c_out_valid, c_out_last, c_out_row});
        end else pass_cnt++;
        tick();
        tick();
        chk_cnt++;
        if ({c_out_valid, c_out_last, c_out_row} !== 4'b1_1_00) begin
            $display("FAIL trail_row1: got v/l/row=%b want 1100",
                     {c_out_valid, c_out_last, c_out_row});
        end else pass_cnt++;
        c_in_row = 5'b11111;
        #1;
        chk_cnt++;
        if (c_in_ready !== 1'b1) begin
            $display("FAIL trail_ready: got in_ready=%b want 1", c_in_ready);
        end else pass_cnt++;
        @(negedge clk);
        chk_cnt++;
        if (c_out_valid !== 1'b0) begin
            $display("FAIL trail_no_output: got out_valid=%b want 0", c_out_valid);
        end else pass_cnt++;
        c_in_row = 5'b00011; tick();
        c_in_row = 5'b00000; tick();
        chk_cnt++;
        if ({c_out_valid, c_out_last, c_out_row} !== 4'b1_0_01) begin
            $display("FAIL trail_next_frame: got v/l/row=%b want 1001",
                     {c_out_valid, c_out_last, c_out_row});
        end else pass_cnt++;
        tick(); tick(); tick();
        c_in_valid = 1'b0; tick();
    endtask

    task automatic test_back_to_back();
        logic [3:0] rows [4];
        logic       lasts [4];
        rows[0] = 4'b0101; lasts[0] = 1'b0;
        rows[1] = 4'b1010; lasts[1] = 1'b0;
        rows[2] = 4'b1111; lasts[2] = 1'b1;
        rows[3] = 4'b0011; lasts[3] = 1'b0;
        p_out_ready = 1'b1;
        p_in_valid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            p_in_row = rows[i];
            tick();
            chk_cnt++;
            if ({p_out_valid, p_out_last, p_out_row} !== {1'b1, lasts[i], rows[i]}) begin
                $display("FAIL b2b_beat%0d: got v/l/row=%b want %b", i,
                         {p_out_valid, p_out_last, p_out_row}, {1'b1, lasts[i], rows[i]});
            end else pass_cnt++;
        end
        p_in_valid = 1'b0; tick();
        chk_cnt++;
        if (p_out_valid !== 1'b0) begin
            $display("FAIL b2b_idle: got out_valid=%b want 0", p_out_valid);
        end else pass_cnt++;
    endtask

`ifdef MAXPOOL_STREAM_FRAME_CNT_EN
    task automatic test_frame_cnt();
        rst = 1'b1; tick();
        rst = 1'b0;
        chk_cnt++;
        if (a_frame_cnt !== 16'd0) begin
            $display("FAIL frame_cnt_reset: got %0d want 0", a_frame_cnt);
        end else pass_cnt++;
        a_out_ready = 1'b1;
        a_in_valid  = 1'b1;
        a_in_row    = 8'h00;
        for (int i = 0; i < 12; i++) tick();
        a_in_valid = 1'b0; tick();
        chk_cnt++;
        if (a_frame_cnt !== 16'd3) begin
            $display("FAIL frame_cnt_three: got %0d want 3", a_frame_cnt);
        end else pass_cnt++;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_single_channel();
        test_channels();
        test_backpressure();
        test_reset_midframe();
        test_trailing();
        test_back_to_back();
`ifdef MAXPOOL_STREAM_FRAME_CNT_EN
        test_frame_cnt();
`endif
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

`default_nettype wire
